// File: rtl/cam_pkg.sv
// Shared camera-path types and constants: capture/replay state encoding,
// replay mode values and the active raster size.
package cam_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAP,
        S_WAIT,
        S_GIVE
    } lcb_state_t;

    localparam logic LCB_MODE_LOOP = 1'b0;
    localparam logic LCB_MODE_ONCE = 1'b1;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;

endpackage

// File: rtl/line_capture_buffer_if.sv
// Raster/pixel input, control and replay stream of the line capture buffer.
interface line_capture_buffer_if #(
    parameter int PIX_W = 15,
    parameter int CNT_W = 13
);
    logic [CNT_W-1:0] i_H_Cont;
    logic [CNT_W-1:0] i_V_Cont;
    logic             i_start;
    logic             i_mode;
    logic             i_pix_valid;
    logic [PIX_W-1:0] i_pix_data;
    logic             i_rd_ready;
    logic             o_rd_valid;
    logic [PIX_W-1:0] o_rd_data;
    logic             o_busy;
    logic             o_capture_done;
    logic             o_replay_wrap;
    logic             o_short_frame;
    logic             o_ccd_pause;

    modport slave (
        input  i_H_Cont, i_V_Cont, i_start, i_mode, i_pix_valid, i_pix_data, i_rd_ready,
        output o_rd_valid, o_rd_data, o_busy, o_capture_done, o_replay_wrap,
               o_short_frame, o_ccd_pause
    );

    modport master (
        output i_H_Cont, i_V_Cont, i_start, i_mode, i_pix_valid, i_pix_data, i_rd_ready,
        input  o_rd_valid, o_rd_data, o_busy, o_capture_done, o_replay_wrap,
               o_short_frame, o_ccd_pause
    );

endinterface

// File: rtl/lcb_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered output that only updates when a read is issued.
module lcb_ram #(
    parameter int PIX_W = 15,
    parameter int DEPTH = 4000
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PIX_W-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PIX_W-1:0]         rdata
);
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // No reset anywhere here so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_capture_buffer.sv
// Captures NUM_LINES x LINE_W pixels from a frame origin into RAM and replays
// them over a valid/ready stream, looping or re-arming after each pass.
module line_capture_buffer
    import cam_pkg::*;
#(
    parameter int PIX_W     = 15,
    parameter int LINE_W    = 800,
    parameter int NUM_LINES = 5,
    parameter int CNT_W     = 13
) (
    input logic                  i_clk,
    input logic                  i_rst,
    line_capture_buffer_if.slave bus
);
    localparam int DEPTH  = LINE_W * NUM_LINES;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    lcb_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              last_q, last_d;
    logic              cap_done_q, cap_done_d;
    logic              short_q, short_d;

    logic              origin, accept, wrap;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_ptr;
    logic [PIX_W-1:0]  ram_rdata;

    assign origin = (bus.i_H_Cont == CNT_W'(0)) && (bus.i_V_Cont == CNT_W'(0));
    assign accept = rd_valid_q && bus.i_rd_ready;
    // last_q marks that the presented pixel came from the final address.
    assign wrap   = accept && last_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = rd_valid_q;
        last_d     = last_q;
        cap_done_d = 1'b0;
        short_d    = 1'b0;
        wr_en      = 1'b0;
        wr_ptr     = wr_addr_q;
        rd_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_ARM;
                    mode_d  = bus.i_mode;
                end
            end
            S_ARM, S_CAP: begin
                if (state_q == S_CAP || origin) begin
                    if (state_q == S_ARM) state_d = S_CAP;
                    // A new origin mid-capture restarts the frame at address 0.
                    if (state_q == S_CAP && origin && wr_addr_q != '0) begin
                        short_d = 1'b1;
                        wr_ptr  = '0;
                    end
                    wr_addr_d = wr_ptr;
                    if (bus.i_pix_valid) begin
                        wr_en = 1'b1;
                        if (wr_ptr == LAST_ADDR) begin
                            wr_addr_d  = '0;
                            cap_done_d = 1'b1;
                            state_d    = S_WAIT;
                        end else begin
                            wr_addr_d = wr_ptr + 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (origin) begin
                    state_d   = S_GIVE;
                    rd_addr_d = '0;
                end
            end
            S_GIVE: begin
                if (!rd_valid_q || bus.i_rd_ready) begin
                    rd_en      = 1'b1;
                    rd_valid_d = 1'b1;
                    last_d     = (rd_addr_q == LAST_ADDR);
                    rd_addr_d  = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
                end
                // One-shot mode drops the prefetched pixel and waits for a new frame.
                if (wrap && mode_q == LCB_MODE_ONCE) begin
                    state_d    = S_ARM;
                    rd_valid_d = 1'b0;
                    last_d     = 1'b0;
                    rd_addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            mode_q     <= LCB_MODE_LOOP;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            last_q     <= 1'b0;
            cap_done_q <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            last_q     <= last_d;
            cap_done_q <= cap_done_d;
            short_q    <= short_d;
        end
    end

    lcb_ram #(
        .PIX_W(PIX_W),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (i_clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(bus.i_pix_data),
        .re   (rd_en),
        .raddr(rd_addr_q),
        .rdata(ram_rdata)
    );

    assign bus.o_busy         = (state_q != S_IDLE);
    assign bus.o_ccd_pause    = (state_q == S_WAIT) || (state_q == S_GIVE);
    assign bus.o_rd_valid     = rd_valid_q;
    // The RAM output register is not reset, so the data is gated by valid.
    assign bus.o_rd_data      = rd_valid_q ? ram_rdata : '0;
    assign bus.o_capture_done = cap_done_q;
    assign bus.o_short_frame  = short_q;
    assign bus.o_replay_wrap  = wrap;

endmodule

// File: tb/tb_line_capture_buffer.sv
// Directed bench for line_capture_buffer with a 16-pixel buffer (8 x 2 lines).
module tb_line_capture_buffer;
    import cam_pkg::*;

    localparam int PIX_W = 15, CNT_W = 13, LINE_W = 8, NUM_LINES = 2, DEPTH = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    line_capture_buffer_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) bus ();

    line_capture_buffer #(
        .PIX_W(PIX_W), .LINE_W(LINE_W), .NUM_LINES(NUM_LINES), .CNT_W(CNT_W)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic             ready;
        logic             exp_valid;
        logic [PIX_W-1:0] exp_data;
        logic             exp_wrap;
    } vec_t;

    vec_t tbl [21];

    int checks = 0, errors = 0;
    int n_done = 0, n_short = 0, n_wrap = 0;

    always @(negedge i_clk) begin
        if (bus.o_capture_done) n_done++;
        if (bus.o_short_frame) n_short++;
        if (bus.o_replay_wrap) n_wrap++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_raster(input bit org);
        bus.i_H_Cont = org ? CNT_W'(0) : CNT_W'(1);
        bus.i_V_Cont = org ? CNT_W'(0) : CNT_W'(1);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
        chk({tag, "_valid"}, int'(bus.o_rd_valid), 0);
        chk({tag, "_data"}, int'(bus.o_rd_data), 0);
        chk({tag, "_pause"}, int'(bus.o_ccd_pause), 0);
        chk({tag, "_done"}, int'(bus.o_capture_done), 0);
        chk({tag, "_wrap"}, int'(bus.o_replay_wrap), 0);
        chk({tag, "_short"}, int'(bus.o_short_frame), 0);
    endtask

    task automatic do_reset(input string tag);
        i_rst = 1'b1;
        #1;
        outputs_zero(tag);
        next();
        i_rst = 1'b0;
    endtask

    task automatic arm(input logic m);
        bus.i_start = 1'b1;
        bus.i_mode  = m;
        next();
        bus.i_start = 1'b0;
        bus.i_mode  = ~m;
        chk("arm_busy", int'(bus.o_busy), 1);
        chk("arm_pause", int'(bus.o_ccd_pause), 0);
    endtask

    // Origin on the first cycle, then DEPTH valid pixels base..base+15.
    task automatic capture(input int base, input bit toggle, input int exp_cyc);
        int n = 0;
        int done_at = -1;
        for (int k = 0; k < 100 && done_at < 0; k++) begin
            set_raster(k == 0);
            bus.i_pix_valid = (n < DEPTH) && (!toggle || (k % 2 == 0));
            bus.i_pix_data  = PIX_W'(base + n);
            if (bus.i_pix_valid) n++;
            @(negedge i_clk);
            if (bus.o_capture_done) begin
                done_at = k;
                chk("cap_pause", int'(bus.o_ccd_pause), 1);
            end
            next();
        end
        set_raster(1'b0);
        bus.i_pix_valid = 1'b0;
        chk("cap_cycles", done_at, exp_cyc);
        chk("cap_done_single", int'(bus.o_capture_done), 0);
    endtask

    task automatic give_start();
        set_raster(1'b1);
        next();
        set_raster(1'b0);
    endtask

    task automatic replay_check(input int base);
        bus.i_rd_ready = 1'b1;
        @(negedge i_clk);
        chk("give_entry_valid", int'(bus.o_rd_valid), 0);
        next();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge i_clk);
            chk($sformatf("rp_valid[%0d]", i), int'(bus.o_rd_valid), 1);
            chk($sformatf("rp_data[%0d]", i), int'(bus.o_rd_data), base + i);
            chk($sformatf("rp_wrap[%0d]", i), int'(bus.o_replay_wrap), int'(i == DEPTH - 1));
            next();
        end
    endtask

    initial begin
        int n0, found;
        set_raster(1'b0);
        bus.i_start = 1'b0;
        bus.i_mode = 1'b0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix_data = '0;
        bus.i_rd_ready = 1'b0;

        // Replay table: stall 3 cycles on pixel 5, then run through the wrap.
        for (int i = 0; i < 21; i++) begin
            if (i == 0)      tbl[i] = '{1'b1, 1'b0, PIX_W'(0), 1'b0};
            else if (i <= 4) tbl[i] = '{1'b1, 1'b1, PIX_W'(i), 1'b0};
            else if (i <= 7) tbl[i] = '{1'b0, 1'b1, PIX_W'(5), 1'b0};
            else if (i == 8) tbl[i] = '{1'b1, 1'b1, PIX_W'(5), 1'b0};
            else if (i <= 19) tbl[i] = '{1'b1, 1'b1, PIX_W'(i - 3), i == 19};
            else             tbl[i] = '{1'b1, 1'b1, PIX_W'(1), 1'b0};
        end

        #2;
        // Tests 1 and 3: loop mode capture, replay with back-pressure and wrap.
        do_reset("rst0");
        chk("idle_busy", int'(bus.o_busy), 0);
        arm(LCB_MODE_LOOP);
        n0 = n_done;
        capture(1, 1'b0, 16);
        chk("t1_done_count", n_done - n0, 1);
        chk("t1_wait_pause", int'(bus.o_ccd_pause), 1);
        n0 = n_wrap;
        give_start();
        for (int i = 0; i < 21; i++) begin
            bus.i_rd_ready = tbl[i].ready;
            @(negedge i_clk);
            chk($sformatf("t3_valid[%0d]", i), int'(bus.o_rd_valid), int'(tbl[i].exp_valid));
            chk($sformatf("t3_data[%0d]", i), int'(bus.o_rd_data), int'(tbl[i].exp_data));
            chk($sformatf("t3_wrap[%0d]", i), int'(bus.o_replay_wrap), int'(tbl[i].exp_wrap));
            next();
        end
        chk("t1_wrap_count", n_wrap - n0, 1);
        chk("t1_loop_pause", int'(bus.o_ccd_pause), 1);

        // Test 2: pixel valid toggling every cycle.
        do_reset("rst2");
        arm(LCB_MODE_LOOP);
        capture(1, 1'b1, 31);
        give_start();
        replay_check(1);

        // Test 4: one-shot mode re-arms, second capture replays new data.
        do_reset("rst4");
        arm(LCB_MODE_ONCE);
        capture(1, 1'b0, 16);
        give_start();
        replay_check(1);
        chk("t4_rearm_valid", int'(bus.o_rd_valid), 0);
        chk("t4_rearm_pause", int'(bus.o_ccd_pause), 0);
        chk("t4_rearm_busy", int'(bus.o_busy), 1);
        capture(32'h100, 1'b0, 16);
        give_start();
        replay_check(32'h100);
        chk("t4_second_pause", int'(bus.o_ccd_pause), 0);

        // Test 5: origin after 5 pixels restarts capture.
        do_reset("rst5");
        arm(LCB_MODE_LOOP);
        n0 = n_short;
        for (int i = 0; i < 5; i++) begin
            set_raster(i == 0);
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data = PIX_W'(32'h900 + i);
            next();
        end
        capture(32'hA00, 1'b0, 16);
        chk("t5_short_count", n_short - n0, 1);
        give_start();
        replay_check(32'hA00);

        // Test 6: asynchronous reset mid-replay, then normal re-arm.
        do_reset("rst6");
        arm(LCB_MODE_LOOP);
        capture(1, 1'b0, 16);
        give_start();
        bus.i_rd_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge i_clk);
            if (bus.o_rd_valid && bus.o_rd_data == PIX_W'(7)) found = 1;
            else next();
        end
        chk("t6_found_7", found, 1);
        #1 i_rst = 1'b1;
        #1 outputs_zero("t6_async");
        next();
        i_rst = 1'b0;
        chk("t6_idle_busy", int'(bus.o_busy), 0);
        arm(LCB_MODE_LOOP);
        capture(32'hB00, 1'b0, 16);
        give_start();
        replay_check(32'hB00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
